// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//   Instruction-memory responder for a fetch unit. A word-addressed memory is
//   read when a fetch request is accepted. The word and an error flag travel
//   through a fixed-latency pipeline into a small output FIFO. A credit counter
//   limits acceptance so that the FIFO can never overflow. A separate
//   program-load port writes words into the memory at any time.
//
// Parameters
//   DEPTH   : memory size in 32-bit words (power of two, 16..4096)
//   LATENCY : cycles from request acceptance to response valid (1..4)
//
// Ports
//   clk        in   sole clock, rising edge
//   reset      in   synchronous active-low reset
//   req_valid  in   fetch request present
//   req_ready  out  request can be accepted this cycle
//   req_addr   in   byte address (PC) of the instruction
//   rsp_valid  out  response present on rsp_data/rsp_err
//   rsp_ready  in   fetch side consumes the response this cycle
//   rsp_data   out  instruction word (NOP when rsp_err=1)
//   rsp_err    out  request was misaligned or out of range
//   ld_en      in   program-load write strobe
//   ld_addr    in   byte address of the load word (bits [1:0] ignored)
//   ld_data    in   word to write
// ---------------------------------------------------------------------------
module imem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int FD = LATENCY + 1;
    localparam int PW = (FD > 2) ? $clog2(FD) : 1;
    localparam int CW = $clog2(FD + 1);
    localparam logic [CW-1:0] FD_C     = CW'(FD);
    localparam logic [PW-1:0] LAST_PTR = PW'(FD - 1);
    localparam logic [31:0]   NOP_WORD = 32'h0000_0013;

    // Pointer advance with explicit wrap, since FD need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    logic [31:0]   mem [DEPTH];

    logic          accept_s;
    logic          pop_s;
    logic          req_err_s;
    logic [31:0]   rd_data_s;
    logic          push_v_s;
    logic [31:0]   push_d_s;
    logic          push_e_s;
    logic          ld_hit_s;
    logic [1:0]    ld_addr_unused_s;

    logic [CW-1:0] credit_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [31:0]   fifo_data_r [FD];
    logic          fifo_err_r  [FD];

    // Load address low bits carry no information for a word write.
    assign ld_addr_unused_s = ld_addr[1:0];

    // Credits cover pipeline plus FIFO, so the FIFO can always take a push.
    // Gating with reset keeps outputs quiet in the very cycle reset is asserted.
    assign req_ready = reset & (credit_r < FD_C);
    assign rsp_valid = reset & (count_r != {CW{1'b0}});
    assign rsp_data  = rsp_valid ? fifo_data_r[rd_ptr_r] : 32'h0000_0000;
    assign rsp_err   = rsp_valid ? fifo_err_r[rd_ptr_r]  : 1'b0;

    assign accept_s  = req_valid & req_ready;
    assign pop_s     = rsp_valid & rsp_ready;

    assign req_err_s = (req_addr[1:0] != 2'b00) | (req_addr[31:AW+2] != '0);
    // Asynchronous read sampled at the accepting edge gives read-before-write.
    assign rd_data_s = req_err_s ? NOP_WORD : mem[req_addr[AW+1:2]];

    assign ld_hit_s  = reset & ld_en & (ld_addr[31:AW+2] == '0);

    // Program-load write port; memory is never cleared by reset.
    always_ff @(posedge clk) begin
        if (ld_hit_s) begin
            mem[ld_addr[AW+1:2]] <= ld_data;
        end
    end

    // The FIFO write is the final latency stage, so LATENCY-1 registers precede it.
    generate
        if (LATENCY == 1) begin : g_direct
            assign push_v_s = accept_s;
            assign push_d_s = rd_data_s;
            assign push_e_s = req_err_s;
        end else begin : g_pipe
            logic        pv_r [LATENCY-1];
            logic [31:0] pd_r [LATENCY-1];
            logic        pe_r [LATENCY-1];

            // Valid chain of the read pipeline, cleared by reset.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        pv_r[i] <= 1'b0;
                    end
                end else begin
                    pv_r[0] <= accept_s;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        pv_r[i] <= pv_r[i-1];
                    end
                end
            end

            // Payload of the read pipeline; meaningful only where the valid is set.
            always_ff @(posedge clk) begin
                pd_r[0] <= rd_data_s;
                pe_r[0] <= req_err_s;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    pd_r[i] <= pd_r[i-1];
                    pe_r[i] <= pe_r[i-1];
                end
            end

            assign push_v_s = pv_r[LATENCY-2];
            assign push_d_s = pd_r[LATENCY-2];
            assign push_e_s = pe_r[LATENCY-2];
        end
    endgenerate

    // Credit counter: entries accepted but not yet consumed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            credit_r <= {CW{1'b0}};
        end else begin
            case ({accept_s, pop_s})
                2'b10:   credit_r <= credit_r + CW'(1);
                2'b01:   credit_r <= credit_r - CW'(1);
                default: credit_r <= credit_r;
            endcase
        end
    end

    // FIFO occupancy and pointers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r  <= {CW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_v_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_v_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; entries are qualified by occupancy so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_v_s) begin
            fifo_data_r[wr_ptr_r] <= push_d_s;
            fifo_err_r[wr_ptr_r]  <= push_e_s;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
//   Directed bench for imem_responder (DEPTH=256, LATENCY=2) followed by a
//   randomized handshake run checked against an in-order scoreboard.
// ---------------------------------------------------------------------------
module tb_imem_responder;

    localparam logic [31:0] W0  = 32'h0010_0093;
    localparam logic [31:0] W1  = 32'h0020_0113;
    localparam logic [31:0] W2  = 32'h0020_81B3;
    localparam logic [31:0] W3  = 32'h0000_0013;
    localparam logic [31:0] W5  = 32'h1111_1111;
    localparam logic [31:0] W7  = 32'h7777_7777;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [256];
    logic [32:0] sb [$];
    logic [31:0] addr_tbl [8];

    imem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        if (a < 32'h400) model_mem[a[9:2]] = d;
        tick();
        ld_en = 1'b0;
    endtask

    function automatic logic [32:0] exp_rsp(input logic [31:0] a);
        if (a[1:0] != 2'b00 || a >= 32'h400) return {1'b1, NOP};
        return {1'b0, model_mem[a[9:2]]};
    endfunction

    initial begin
        int acc_n;
        int outstanding;
        logic [31:0] s_addr [3];

        reset = 1'b0; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b0;
        ld_en = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;

        // Reset state
        tick(); tick(); tick();
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_data",  rsp_data,  0);
        check_val("rst_rsp_err",   rsp_err,   0);
        reset = 1'b1;
        #1;
        check_val("rel_req_ready", req_ready, 1);

        // Program load, including an out-of-range word that must be dropped
        load(32'h0, W0); load(32'h4, W1); load(32'h8, W2); load(32'hC, W3);
        load(32'h14, W5); load(32'h1F, W7);
        load(32'h400, 32'hBADB_AD00);

        // Back-to-back in-order fetch with rsp_ready held
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 32'h0; tick();
        check_val("b2b_lat_empty", rsp_valid, 0);
        req_addr = 32'h4; #1;
        check_val("b2b_ready", req_ready, 1);
        tick();
        check_val("b2b_w0", {rsp_valid, rsp_err, rsp_data}, {2'b10, W0});
        req_addr = 32'h8; tick();
        check_val("b2b_w1", {rsp_valid, rsp_err, rsp_data}, {2'b10, W1});
        req_addr = 32'hC; #1;
        check_val("b2b_ready2", req_ready, 1);
        tick();
        check_val("b2b_w2", {rsp_valid, rsp_err, rsp_data}, {2'b10, W2});
        req_valid = 1'b0; tick();
        check_val("b2b_w3", {rsp_valid, rsp_err, rsp_data}, {2'b10, W3});
        tick();
        check_val("b2b_drained", rsp_valid, 0);

        // Misaligned and out-of-range requests
        req_valid = 1'b1; req_addr = 32'h6; tick();
        req_addr = 32'h400; tick();
        req_valid = 1'b0;
        check_val("err_mis", {rsp_valid, rsp_err, rsp_data}, {2'b11, NOP});
        tick();
        check_val("err_oor", {rsp_valid, rsp_err, rsp_data}, {2'b11, NOP});
        tick();
        check_val("err_drained", rsp_valid, 0);

        // Stall: only LATENCY+1 requests may be accepted
        rsp_ready = 1'b0; req_valid = 1'b1; acc_n = 0;
        s_addr[0] = 32'h0; s_addr[1] = 32'h4; s_addr[2] = 32'h8;
        for (int i = 0; i < 6; i++) begin
            req_addr = (acc_n < 3) ? s_addr[acc_n] : 32'hC;
            #1;
            if (req_ready) acc_n++;
            tick();
        end
        req_valid = 1'b0;
        check_val("stall_accepted", acc_n, 3);
        check_val("stall_ready_low", req_ready, 0);
        check_val("stall_head", {rsp_valid, rsp_data}, {1'b1, W0});
        tick();
        check_val("stall_stable", {rsp_valid, rsp_err, rsp_data}, {2'b10, W0});
        rsp_ready = 1'b1; tick();
        check_val("stall_w1", {rsp_valid, rsp_data}, {1'b1, W1});
        tick();
        check_val("stall_w2", {rsp_valid, rsp_data}, {1'b1, W2});
        tick();
        check_val("stall_drained", rsp_valid, 0);

        // Same-cycle load and fetch of word 5: read-before-write
        req_valid = 1'b1; req_addr = 32'h14;
        ld_en = 1'b1; ld_addr = 32'h14; ld_data = 32'hDEAD_BEEF;
        model_mem[5] = 32'hDEAD_BEEF;
        tick();
        ld_en = 1'b0; tick();
        req_valid = 1'b0;
        check_val("rbw_old", rsp_data, W5);
        tick();
        check_val("rbw_new", rsp_data, 32'hDEAD_BEEF);
        tick();

        // Reset with requests in flight; load during reset must be ignored
        rsp_ready = 1'b0; req_valid = 1'b1;
        req_addr = 32'h0; tick();
        req_addr = 32'h4; tick();
        req_addr = 32'h8; tick();
        req_valid = 1'b0; reset = 1'b0;
        ld_en = 1'b1; ld_addr = 32'h1C; ld_data = 32'hBAD0_BAD0;
        #1;
        check_val("mid_rst_ready", req_ready, 0);
        check_val("mid_rst_valid", rsp_valid, 0);
        tick();
        check_val("mid_rst_out", {req_ready, rsp_valid, rsp_err, rsp_data}, 35'h0);
        reset = 1'b1; ld_en = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("post_rst_no_stale", rsp_valid, 0);
        end
        req_valid = 1'b1; req_addr = 32'h1C; tick();
        req_addr = 32'h4; tick();
        check_val("reread_w7", {rsp_valid, rsp_data}, {1'b1, W7});
        req_addr = 32'h0; tick();
        req_valid = 1'b0;
        check_val("reread_w1", {rsp_valid, rsp_data}, {1'b1, W1});
        tick();
        check_val("reread_w0", {rsp_valid, rsp_data}, {1'b1, W0});
        tick();

        // Random handshakes against the scoreboard
        addr_tbl[0] = 32'h0;  addr_tbl[1] = 32'h4;  addr_tbl[2] = 32'h8;
        addr_tbl[3] = 32'hC;  addr_tbl[4] = 32'h14; addr_tbl[5] = 32'h1C;
        addr_tbl[6] = 32'h6;  addr_tbl[7] = 32'h400;
        outstanding = 0;
        for (int c = 0; c < 10000; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = addr_tbl[$urandom_range(0, 7)];
            rsp_ready = 1'($urandom_range(0, 1));
            #1;
            check_val("rnd_credit", req_ready, 64'(outstanding < 3));
            if (rsp_valid && rsp_ready) begin
                check_val("rnd_expected", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) check_val("rnd_rsp", {rsp_err, rsp_data}, sb.pop_front());
                outstanding--;
            end
            if (req_valid && req_ready) begin
                sb.push_back(exp_rsp(req_addr));
                outstanding++;
            end
            tick();
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (rsp_valid) begin
                check_val("drain_expected", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) check_val("drain_rsp", {rsp_err, rsp_data}, sb.pop_front());
            end
            tick();
        end
        check_val("drain_empty", sb.size(), 0);
        check_val("drain_valid_low", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH, default 256: instruction memory size in 32-bit words; power of two, 16..4096.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to response valid; range 1..4.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
REQ-005 req_valid  input  1  fetch request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_addr  input  32  byte address of the instruction (the PC).
REQ-008 rsp_valid  output  1  response present on rsp_data/rsp_err.
REQ-009 rsp_ready  input  1  fetch side accepts the response this cycle.
REQ-010 rsp_data  output  32  instruction word.
REQ-011 rsp_err  output  1  request was misaligned or out of range.
REQ-012 ld_en  input  1  program-load write strobe.
REQ-013 ld_addr  input  32  byte address of load word (bits [1:0] ignored).
REQ-014 ld_data  input  32  word to write.

Function
REQ-015 A request SHALL be accepted on a cycle with req_valid=1 and req_ready=1; a response SHALL be consumed on a cycle with rsp_valid=1 and rsp_ready=1.
REQ-016 Memory SHALL be read at acceptance: index = req_addr[log2(DEPTH)+1:2]; the word and error flag SHALL travel through a LATENCY-stage valid-tagged pipeline.
REQ-017 rsp_err SHALL be 1 when req_addr[1:0]!=0 or req_addr>=4*DEPTH; rsp_data SHALL then be 32'h00000013 (addi x0,x0,0).
REQ-018 Pipeline outputs SHALL enter an output FIFO of LATENCY+1 entries; rsp_valid SHALL equal FIFO non-empty; rsp_data/rsp_err SHALL show the FIFO head.
REQ-019 With an empty FIFO and rsp_ready=1, a response accepted in cycle N SHALL appear with rsp_valid=1 in cycle N+LATENCY.
REQ-020 Credit rule: req_ready SHALL be 1 iff (in-flight pipeline entries + FIFO occupancy) < LATENCY+1, counted with registered state only; req_ready SHALL NOT depend combinationally on req_valid or rsp_ready.
REQ-021 Responses SHALL return in request order; none SHALL be dropped or duplicated under any rsp_ready pattern.
REQ-022 rsp_data/rsp_err SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-023 Full throughput: with rsp_ready held 1, one request per cycle SHALL be accepted indefinitely.
REQ-024 FIFO pointers SHALL wrap modulo LATENCY+1; simultaneous push and pop at full or empty SHALL leave occupancy unchanged and keep data correct.
REQ-025 ld_en=1 SHALL write ld_data to word ld_addr[log2(DEPTH)+1:2] at the clock edge; out-of-range ld_addr SHALL be ignored; ld_en SHALL be accepted every cycle regardless of handshake state.
REQ-026 Same-cycle load and accepted request to the same word SHALL return the old word (read-before-write); a request accepted one cycle later SHALL return the new word.

Reset
REQ-027 While reset=0: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0; pipeline valids and FIFO occupancy cleared.
REQ-028 req_ready SHALL be 1 on the first cycle after reset returns to 1.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight and queued responses; none SHALL appear after release.
REQ-030 Memory contents SHALL NOT be altered by reset; ld_en SHALL be ignored while reset=0.

Verification
REQ-031 Load words 0..3 = 0x00100093,0x00200113,0x002081B3,0x00000013; rsp_ready=1; requests 0x0,0x4,0x8,0xC back-to-back -> same four words in order, first at acceptance+LATENCY, one per cycle, rsp_err=0.
REQ-032 Request 0x6, then 0x400 (DEPTH=256) -> two responses rsp_data=0x00000013, rsp_err=1.
REQ-033 rsp_ready=0, requests streamed -> exactly LATENCY+1 accepted, req_ready then 0; release rsp_ready -> all return in order, stable while stalled.
REQ-034 Same cycle: ld_en to word 5 with 0xDEADBEEF and request 0x14 (old 0x11111111) -> 0x11111111; next request 0x14 -> 0xDEADBEEF.
REQ-035 Three requests in flight, reset=0 one cycle -> rsp_valid=0 and req_ready=0 during reset, no stale responses after, memory intact on re-read.
REQ-036 Random req_valid/rsp_ready (50%) over 10000 cycles vs scoreboard -> in-order, no loss, no credit overflow.
